hc_sr04_multi_fsm: RTL and testbench

Multi-channel ultrasonic ranging controller for up to N_CH HC-SR04-style sensors. It shares one trigger/echo measurement engine among all channels and services them in round-robin order. It writes a per-channel range and timeout flag and pulses a result-valid strobe. It sits between the shared microsecond/sample-rate strobe generators and the display/bus logic, and adds over the single-sensor ranger: channel count, single-sweep vs. continuous mode, echo synchronisation, timeout detection and range saturation.

---
 rtl/hc_sr04_multi_fsm.sv | 183 ++++++++++++++++++
 tb/tb_hc_sr04_multi_fsm.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc_sr04_multi_fsm.sv
// Round-robin HC-SR04 ranging controller: one shared trigger/echo engine
// services N_CH sensors and keeps a per-channel range and timeout flag.
module hc_sr04_multi_fsm #(
    parameter int N_CH          = 4,
    parameter int DELAY_TRIGGER = 10,
    parameter int DELAY_ECHO    = 25000,
    parameter int DELAY_POSTFIX = 500000,
    parameter int DELAY_WIDTH   = $clog2(
        (DELAY_POSTFIX > DELAY_ECHO)
            ? ((DELAY_POSTFIX > DELAY_TRIGGER) ? DELAY_POSTFIX : DELAY_TRIGGER)
            : ((DELAY_ECHO > DELAY_TRIGGER) ? DELAY_ECHO : DELAY_TRIGGER)) + 1,
    parameter int RANGE_WIDTH   = 16,
    parameter int CH_WIDTH      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          strobe_us,
    input  logic                          strobe_sm,
    input  logic                          start,
    input  logic                          cont,
    input  logic [N_CH-1:0]               echo,
    output logic [N_CH-1:0]               trigger,
    output logic [N_CH*RANGE_WIDTH-1:0]   range,
    output logic [N_CH-1:0]               timeout,
    output logic                          valid,
    output logic [CH_WIDTH-1:0]           valid_ch,
    output logic                          busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIGGER,
        S_ECHO,
        S_SAVE,
        S_POSTFIX
    } state_t;

    localparam logic [DELAY_WIDTH-1:0] D_TRIG    = DELAY_WIDTH'(DELAY_TRIGGER);
    localparam logic [DELAY_WIDTH-1:0] D_ECHO    = DELAY_WIDTH'(DELAY_ECHO);
    localparam logic [DELAY_WIDTH-1:0] D_POST    = DELAY_WIDTH'(DELAY_POSTFIX);
    localparam logic [CH_WIDTH-1:0]    CH_LAST   = CH_WIDTH'(N_CH - 1);
    localparam logic [RANGE_WIDTH-1:0] RANGE_MAX = '1;

    state_t                               state_q, state_d;
    logic [CH_WIDTH-1:0]                  ch_q, ch_d;
    logic [DELAY_WIDTH-1:0]               delay_q, delay_d;
    logic [RANGE_WIDTH-1:0]               range_cnt_q, range_cnt_d;
    logic                                 echo_seen_q, echo_seen_d;
    logic                                 echo_late_q, echo_late_d;
    logic [N_CH-1:0]                      echo_meta_q, echo_sync_q;
    logic [N_CH-1:0][RANGE_WIDTH-1:0]     range_q, range_d;
    logic [N_CH-1:0]                      timeout_q, timeout_d;
    logic [N_CH-1:0]                      trigger_q, trigger_d;
    logic                                 valid_q, valid_d;
    logic [CH_WIDTH-1:0]                  valid_ch_q, valid_ch_d;
    logic                                 busy_q, busy_d;
    logic                                 echo_s;

    assign echo_s = echo_sync_q[ch_q];

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        ch_d        = ch_q;
        range_cnt_d = range_cnt_q;
        echo_seen_d = echo_seen_q;
        echo_late_d = echo_late_q;
        range_d     = range_q;
        timeout_d   = timeout_q;
        valid_d     = 1'b0;
        valid_ch_d  = valid_ch_q;

        case (state_q)
            S_IDLE: begin
                if (start || cont) begin
                    state_d = S_TRIGGER;
                    ch_d    = '0;
                end
            end
            S_TRIGGER: begin
                if (delay_q == D_TRIG) state_d = S_ECHO;
            end
            S_ECHO: begin
                if (strobe_sm && echo_s && (range_cnt_q != RANGE_MAX))
                    range_cnt_d = range_cnt_q + 1'b1;
                if (echo_s) echo_seen_d = 1'b1;
                // An echo still high when the window closes is an unfinished pulse.
                if (delay_q == D_ECHO) begin
                    state_d     = S_SAVE;
                    echo_late_d = echo_s;
                end
            end
            S_SAVE: begin
                state_d = S_POSTFIX;
                if (!echo_seen_q || echo_late_q) begin
                    timeout_d[ch_q] = 1'b1;
                    range_d[ch_q]   = RANGE_MAX;
                end else begin
                    timeout_d[ch_q] = 1'b0;
                    range_d[ch_q]   = range_cnt_q;
                end
                valid_d    = 1'b1;
                valid_ch_d = ch_q;
            end
            S_POSTFIX: begin
                if (delay_q == D_POST) begin
                    if (ch_q != CH_LAST) begin
                        ch_d    = ch_q + 1'b1;
                        state_d = S_TRIGGER;
                    end else if (cont) begin
                        ch_d    = '0;
                        state_d = S_TRIGGER;
                    end else begin
                        ch_d    = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_d == S_TRIGGER) && (state_q != S_TRIGGER)) begin
            range_cnt_d = '0;
            echo_seen_d = 1'b0;
            echo_late_d = 1'b0;
        end

        if (state_d != state_q)
            delay_d = '0;
        else if (strobe_us)
            delay_d = delay_q + 1'b1;
        else
            delay_d = delay_q;

        for (int i = 0; i < N_CH; i++)
            trigger_d[i] = (state_d == S_TRIGGER) && (ch_d == CH_WIDTH'(i));
        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            delay_q     <= '0;
            range_cnt_q <= '0;
            echo_seen_q <= 1'b0;
            echo_late_q <= 1'b0;
            echo_meta_q <= '0;
            echo_sync_q <= '0;
            // NOTE: the result bank is reset too, since a reset must clear all published ranges.
            range_q     <= '0;
            timeout_q   <= '0;
            trigger_q   <= '0;
            valid_q     <= 1'b0;
            valid_ch_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            delay_q     <= delay_d;
            range_cnt_q <= range_cnt_d;
            echo_seen_q <= echo_seen_d;
            echo_late_q <= echo_late_d;
            echo_meta_q <= echo;
            echo_sync_q <= echo_meta_q;
            range_q     <= range_d;
            timeout_q   <= timeout_d;
            trigger_q   <= trigger_d;
            valid_q     <= valid_d;
            valid_ch_q  <= valid_ch_d;
            busy_q      <= busy_d;
        end
    end

    assign trigger  = trigger_q;
    assign range    = range_q;
    assign timeout  = timeout_q;
    assign valid    = valid_q;
    assign valid_ch = valid_ch_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_hc_sr04_multi_fsm.sv
// Bench for hc_sr04_multi_fsm: a timeline model of the measurement schedule is
// compared against two instances (8-bit and 4-bit range) every clock.
module tb_hc_sr04_multi_fsm;

    localparam int N  = 2;
    localparam int DT = 2;
    localparam int DE = 20;
    localparam int DP = 3;

    // Offsets from the edge on which a channel's trigger starts.
    localparam int ECHO_LO  = DT + 2;
    localparam int ECHO_HI  = DT + DE + 2;
    localparam int SAVE_OFF = DT + DE + 3;
    localparam int END_OFF  = DT + DE + DP + 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        strobe_us;
    logic        strobe_sm;
    logic        start;
    logic        cont;
    logic [1:0]  echo;
    logic        sm_div;

    logic [1:0]  trig8, trig4, to8, to4;
    logic [15:0] range8;
    logic [7:0]  range4;
    logic        valid8, valid4, busy8, busy4;
    logic        vch8, vch4;

    hc_sr04_multi_fsm #(
        .N_CH(N), .DELAY_TRIGGER(DT), .DELAY_ECHO(DE), .DELAY_POSTFIX(DP), .RANGE_WIDTH(8)
    ) u_dut8 (
        .clk(clk), .rst(rst), .strobe_us(strobe_us), .strobe_sm(strobe_sm),
        .start(start), .cont(cont), .echo(echo), .trigger(trig8), .range(range8),
        .timeout(to8), .valid(valid8), .valid_ch(vch8), .busy(busy8)
    );

    hc_sr04_multi_fsm #(
        .N_CH(N), .DELAY_TRIGGER(DT), .DELAY_ECHO(DE), .DELAY_POSTFIX(DP), .RANGE_WIDTH(4)
    ) u_dut4 (
        .clk(clk), .rst(rst), .strobe_us(strobe_us), .strobe_sm(strobe_sm),
        .start(start), .cont(cont), .echo(echo), .trigger(trig4), .range(range4),
        .timeout(to4), .valid(valid4), .valid_ch(vch4), .busy(busy4)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int   cyc = 0;
    bit   m_busy;
    int   m_ch, m_seg, m_cnt, m_vch;
    bit   m_seen, m_hi, m_valid;
    int   m_raw [N];
    bit   m_to  [N];
    bit [1:0] m_h1, m_h2;

    task automatic model_step();
        bit es;
        int off;
        if (rst) begin
            m_busy = 0; m_ch = 0; m_seg = 0; m_cnt = 0; m_vch = 0;
            m_seen = 0; m_hi = 0; m_valid = 0; m_h1 = '0; m_h2 = '0;
            for (int c = 0; c < N; c++) begin m_raw[c] = 0; m_to[c] = 0; end
            return;
        end
        m_valid = 0;
        es = m_h2[m_ch];
        m_h2 = m_h1;
        m_h1 = echo;
        if (!m_busy) begin
            if (start || cont) begin
                m_busy = 1; m_ch = 0; m_seg = cyc; m_cnt = 0; m_seen = 0; m_hi = 0;
            end
        end else begin
            off = cyc - m_seg;
            if (off >= ECHO_LO && off <= ECHO_HI) begin
                if (es && strobe_sm) m_cnt++;
                if (es) m_seen = 1;
                if (off == ECHO_HI) m_hi = es;
            end else if (off == SAVE_OFF) begin
                m_to[m_ch]  = !m_seen || m_hi;
                m_raw[m_ch] = m_cnt;
                m_valid = 1;
                m_vch   = m_ch;
            end else if (off == END_OFF) begin
                if (m_ch < N - 1) begin
                    m_ch++; m_seg = cyc; m_cnt = 0; m_seen = 0; m_hi = 0;
                end else if (cont) begin
                    m_ch = 0; m_seg = cyc; m_cnt = 0; m_seen = 0; m_hi = 0;
                end else begin
                    m_busy = 0; m_ch = 0;
                end
            end
        end
    endtask

    function automatic int exp_range(input int c, input int rw);
        int mx;
        mx = (1 << rw) - 1;
        if (m_to[c]) return mx;
        return (m_raw[c] > mx) ? mx : m_raw[c];
    endfunction

    task automatic compare_all();
        logic [1:0]  et;
        logic [15:0] e8;
        logic [7:0]  e4;
        et = '0;
        if (m_busy && (cyc - m_seg) <= DT) et[m_ch] = 1'b1;
        e8 = {8'(exp_range(1, 8)), 8'(exp_range(0, 8))};
        e4 = {4'(exp_range(1, 4)), 4'(exp_range(0, 4))};
        check("trigger8", trig8, et);
        check("trigger4", trig4, et);
        check("busy8", busy8, m_busy);
        check("busy4", busy4, m_busy);
        check("valid8", valid8, m_valid);
        check("valid4", valid4, m_valid);
        check("valid_ch8", vch8, m_vch);
        check("valid_ch4", vch4, m_vch);
        check("timeout8", to8, {m_to[1], m_to[0]});
        check("timeout4", to4, {m_to[1], m_to[0]});
        check("range8", range8, e8);
        check("range4", range4, e4);
    endtask

    // Observations used by the hand-computed checks.
    int       n_trig0 = 0, n_trig1 = 0, n_valid = 0;
    int       trig0_rise[$], trig1_rise[$], vch_seen[$];
    int       busy_rise = 0, busy_fall = 0;
    logic [1:0] prev_trig = '0;
    logic     prev_busy = 1'b0;

    task automatic monitor();
        if (trig8 == 2'b01) n_trig0++;
        if (trig8 == 2'b10) n_trig1++;
        if (trig8 == 2'b01 && prev_trig != 2'b01) trig0_rise.push_back(cyc);
        if (trig8 == 2'b10 && prev_trig != 2'b10) trig1_rise.push_back(cyc);
        prev_trig = trig8;
        if (valid8) begin n_valid++; vch_seen.push_back(int'(vch8)); end
        if (busy8 && !prev_busy) busy_rise = cyc;
        if (!busy8 && prev_busy) busy_fall = cyc;
        prev_busy = busy8;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            model_step();
            compare_all();
            monitor();
        end
    end

    initial begin
        strobe_sm = 1'b1;
        forever begin
            @(negedge clk);
            strobe_sm = sm_div ? ~strobe_sm : 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while (busy8 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, busy8, 1'b0);
    endtask

    int b_t0, b_t1, b_v, b_r0, b_r1, b_q;

    task automatic snap();
        b_t0 = n_trig0; b_t1 = n_trig1; b_v = n_valid;
        b_r0 = trig0_rise.size(); b_r1 = trig1_rise.size(); b_q = vch_seen.size();
    endtask

    initial begin
        rst = 1'b1; strobe_us = 1'b1; start = 1'b0; cont = 1'b0; echo = 2'b00; sm_div = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);
        check("reset_busy", busy8, 1'b0);
        check("reset_range", range8, 16'h0000);
        check("reset_timeout", to8, 2'b00);

        // Single sweep, 7-clock echo on ch0, none on ch1.
        snap();
        pulse_start();
        tick(4); echo[0] = 1'b1;
        tick(7); echo[0] = 1'b0;
        wait_idle("t1_idle", 100);
        check("t1_range_ch0", range8[7:0], 8'd7);
        check("t1_range_ch1", range8[15:8], 8'hFF);
        check("t1_timeout", to8, 2'b10);
        check("t1_range4", range4, 8'hF7);
        check("t1_trig0_width", n_trig0 - b_t0, 3);
        check("t1_trig1_width", n_trig1 - b_t1, 3);
        check("t1_valid_count", n_valid - b_v, 2);
        check("t1_vch_first", vch_seen[b_q], 0);
        check("t1_vch_second", vch_seen[b_q + 1], 1);
        check("t1_ch_period", trig1_rise[b_r1] - trig0_rise[b_r0], 29);
        check("t1_busy_len", busy_fall - busy_rise, 58);

        // ch0 echo stuck high through its window; ch1 sees a 5-clock pulse.
        tick(2);
        pulse_start();
        echo[0] = 1'b1;
        tick(33); echo[1] = 1'b1;
        tick(5);  echo[1] = 1'b0;
        wait_idle("t2_idle", 100);
        echo[0] = 1'b0;
        check("t2_range8", range8, 16'h05FF);
        check("t2_timeout", to8, 2'b01);
        check("t2_range4", range4, 8'h5F);

        // 18-clock echo: saturates the 4-bit range, ends before the window closes.
        tick(3);
        pulse_start();
        tick(2); echo[0] = 1'b1;
        tick(18); echo[0] = 1'b0;
        wait_idle("t3_idle", 100);
        check("t3_range4", range4, 8'hFF);
        check("t3_timeout4", to4, 2'b10);
        check("t3_range8", range8, 16'hFF12);

        // Continuous mode with a slower sample strobe; cont dropped mid second sweep.
        tick(2);
        snap();
        sm_div = 1'b1;
        @(negedge clk); cont = 1'b1;
        @(negedge clk);
        tick(4); echo[0] = 1'b1;
        tick(6); echo[0] = 1'b0;
        tick(58); cont = 1'b0;
        wait_idle("t4_idle", 200);
        sm_div = 1'b0;
        check("t4_trig0_count", n_trig0 - b_t0, 6);
        check("t4_trig1_count", n_trig1 - b_t1, 6);
        check("t4_valid_count", n_valid - b_v, 4);
        check("t4_sweep_period", trig0_rise[b_r0 + 1] - trig0_rise[b_r0], 58);
        check("t4_busy_len", busy_fall - busy_rise, 116);
        check("t4_vch_third", vch_seen[b_q + 2], 0);

        // Asynchronous reset while ch0 trigger is high.
        tick(2);
        pulse_start();
        tick(1);
        check("t5_trig_before", trig8, 2'b01);
        #2 rst = 1'b1;
        #1;
        check("t5_trig_async", trig8, 2'b00);
        check("t5_busy_async", busy8, 1'b0);
        check("t5_range_async", range8, 16'h0000);
        @(negedge clk); rst = 1'b0;

        // Asynchronous reset during ch1 echo window.
        tick(2);
        pulse_start();
        tick(4); echo[0] = 1'b1;
        tick(4); echo[0] = 1'b0;
        tick(30); echo[1] = 1'b1;
        tick(1);
        check("t6_busy_before", busy8, 1'b1);
        check("t6_range0_before", range8[7:0], 8'd4);
        #2 rst = 1'b1;
        #1;
        check("t6_trig_async", trig8, 2'b00);
        check("t6_range8_async", range8, 16'h0000);
        check("t6_range4_async", range4, 8'h00);
        check("t6_timeout_async", to8, 2'b00);
        check("t6_valid_async", valid8, 1'b0);
        check("t6_busy_async", busy8, 1'b0);
        @(negedge clk);
        @(negedge clk); rst = 1'b0; echo[1] = 1'b0;
        tick(2);
        pulse_start();
        check("t6_restart_ch0", trig8, 2'b01);
        wait_idle("t6_idle", 100);
        check("t6_final_timeout", to8, 2'b11);

        tick(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
